// File: rtl/dbg_dump_pkg.sv
// Shared FSM type and sizing constants for the debug dump unit.
package dbg_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_REGS = 3'd2,
        ST_MEM  = 3'd3,
        ST_CSUM = 3'd4
    } dump_state_e;

    localparam int unsigned HDR_WORDS = 4;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned WORD_W    = 32;
    // Index within the current frame section; wide enough for large memory dumps.
    localparam int unsigned IDX_W     = 16;

endpackage

// File: rtl/dbg_perf_counters.sv
// Cycle/stall/flush counters plus the header snapshot taken when a dump starts.
module dbg_perf_counters
    import dbg_dump_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic              branch_i,
    input  logic              flush_i,
    input  logic [WORD_W-1:0] pc_i,
    input  logic              snap_i,
    output logic [WORD_W-1:0] cyc_o,
    output logic [WORD_W-1:0] pc_snap_o,
    output logic [WORD_W-1:0] stl_snap_o,
    output logic [WORD_W-1:0] fls_snap_o
);

    logic [CNT_W-1:0]  cyc_q;
    logic [CNT_W-1:0]  stl_q;
    logic [CNT_W-1:0]  fls_q;
    logic [CNT_W-1:0]  stl_snap_q;
    logic [CNT_W-1:0]  fls_snap_q;
    logic [WORD_W-1:0] pc_snap_q;

    // Cycle 0 of the frame is loaded straight from cyc_q, so only the later header words need a snapshot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q      <= '0;
            stl_q      <= '0;
            fls_q      <= '0;
            stl_snap_q <= '0;
            fls_snap_q <= '0;
            pc_snap_q  <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (stall_i && !jump_i && !branch_i) begin
                stl_q <= stl_q + CNT_W'(1);
            end
            if (flush_i) begin
                fls_q <= fls_q + CNT_W'(1);
            end
            if (snap_i) begin
                stl_snap_q <= stl_q;
                fls_snap_q <= fls_q;
                pc_snap_q  <= pc_i;
            end
        end
    end

    assign cyc_o      = WORD_W'(cyc_q);
    assign pc_snap_o  = pc_snap_q;
    assign stl_snap_o = WORD_W'(stl_snap_q);
    assign fls_snap_o = WORD_W'(fls_snap_q);

endmodule

// File: rtl/dbg_dump_unit.sv
// Serialises a counter/PC/register/memory snapshot frame over a valid/ready word stream.
// Define DBG_CHECKSUM_EN to append an XOR checksum word to every frame.
module dbg_dump_unit
    import dbg_dump_pkg::*;
#(
    parameter int unsigned NUM_MEM_WORDS = 8,
    parameter int unsigned CNT_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic              branch_i,
    input  logic              flush_i,
    input  logic [WORD_W-1:0] pc_i,
    input  logic              req_i,
    output logic [4:0]        rf_addr_o,
    input  logic [WORD_W-1:0] rf_data_i,
    output logic [WORD_W-1:0] dm_addr_o,
    input  logic [WORD_W-1:0] dm_data_i,
    output logic [WORD_W-1:0] dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              dout_last_o,
    output logic              busy_o
);

    dump_state_e       state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] dout_q;
    logic              dout_valid_q;
    logic              dout_last_q;
    logic              busy_q;
`ifdef DBG_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q;
`endif

    logic [WORD_W-1:0] cyc_w;
    logic [WORD_W-1:0] pc_snap_w;
    logic [WORD_W-1:0] stl_snap_w;
    logic [WORD_W-1:0] fls_snap_w;
    logic [WORD_W-1:0] word_c;
    logic              snap_c;
    logic              fire_c;

    dbg_perf_counters #(
        .CNT_W(CNT_W)
    ) u_counters (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .stall_i    (stall_i),
        .jump_i     (jump_i),
        .branch_i   (branch_i),
        .flush_i    (flush_i),
        .pc_i       (pc_i),
        .snap_i     (snap_c),
        .cyc_o      (cyc_w),
        .pc_snap_o  (pc_snap_w),
        .stl_snap_o (stl_snap_w),
        .fls_snap_o (fls_snap_w)
    );

    // A word is loaded on the request itself, or whenever the output slot is free and more words remain.
    assign snap_c = (state_q == ST_IDLE) && req_i;
    assign fire_c = snap_c ||
                    ((state_q != ST_IDLE) && !dout_last_q && (!dout_valid_q || dout_ready_i));

    // Debug read ports point at the word that the next load will capture.
    assign rf_addr_o = (state_q == ST_REGS) ? idx_q[4:0] : 5'd0;
    assign dm_addr_o = (state_q == ST_MEM) ? WORD_W'({idx_q, 2'b00}) : '0;

    always_comb begin
        word_c = '0;
        case (state_q)
            ST_IDLE: word_c = cyc_w;
            ST_HDR: begin
                case (idx_q[1:0])
                    2'd1:    word_c = pc_snap_w;
                    2'd2:    word_c = stl_snap_w;
                    2'd3:    word_c = fls_snap_w;
                    default: word_c = cyc_w;
                endcase
            end
            ST_REGS: word_c = rf_data_i;
            ST_MEM:  word_c = dm_data_i;
`ifdef DBG_CHECKSUM_EN
            ST_CSUM: word_c = csum_q;
`endif
            default: word_c = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef DBG_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else if (fire_c) begin
            dout_q       <= word_c;
            dout_valid_q <= 1'b1;
`ifdef DBG_CHECKSUM_EN
            csum_q       <= snap_c ? word_c : (csum_q ^ word_c);
`endif
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_HDR;
                    idx_q   <= IDX_W'(1);
                    busy_q  <= 1'b1;
                end
                ST_HDR: begin
                    if (idx_q == IDX_W'(HDR_WORDS - 1)) begin
                        state_q <= ST_REGS;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_REGS: begin
                    if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                        state_q <= ST_MEM;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_MEM: begin
                    if (idx_q == IDX_W'(NUM_MEM_WORDS - 1)) begin
`ifdef DBG_CHECKSUM_EN
                        state_q <= ST_CSUM;
                        idx_q   <= '0;
`else
                        dout_last_q <= 1'b1;
`endif
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
`ifdef DBG_CHECKSUM_EN
                ST_CSUM: dout_last_q <= 1'b1;
`endif
                default: state_q <= ST_IDLE;
            endcase
        end else if (dout_valid_q && dout_ready_i) begin
            // Only the final word can be accepted without a follow-on load.
            dout_valid_q <= 1'b0;
            if (dout_last_q) begin
                dout_last_q <= 1'b0;
                busy_q      <= 1'b0;
                state_q     <= ST_IDLE;
                idx_q       <= '0;
            end
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign dout_last_o  = dout_last_q;
    assign busy_o       = busy_q;

endmodule
